vram_port_arbiter: RTL

// - Shares one VRAM CPU-side port (cpu_addr/cpu_d/cpu_we/cpu_q) between two requesters.
//   - Requester 0: MemoryUnit.
//   - Requester 1: the planned VRAM copy/fill engine.
// - Sits between the requesters and the VRAM instance. Runs entirely in the clk domain.
// - Round-robin grant, one transaction in flight.
// - Latches address/data/we at grant and returns read data with a one-cycle done pulse.

---
 rtl/vram_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vram_port_arbiter.sv
// Two-requester round-robin arbiter for the VRAM CPU-side port.
// One transaction in flight; request fields are latched at grant and read data returns with a done pulse.
module vram_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_d,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_q,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_d,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_q,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_d,
  output logic              vram_we,
  input  logic [DATA_W-1:0] vram_q,
  output logic              busy
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic              owner, owner_n;
  logic              last, last_n;
  logic              op_we, op_we_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] vram_addr_n;
  logic [DATA_W-1:0] vram_d_n;
  logic              vram_we_n;
  logic              r0_done_n, r1_done_n;
  logic [DATA_W-1:0] r0_q_n, r1_q_n;
  logic              busy_n;
  logic              win;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      op_we     <= 1'b0;
      cnt       <= '0;
      vram_addr <= '0;
      vram_d    <= '0;
      vram_we   <= 1'b0;
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_q      <= '0;
      r1_q      <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      last      <= last_n;
      op_we     <= op_we_n;
      cnt       <= cnt_n;
      vram_addr <= vram_addr_n;
      vram_d    <= vram_d_n;
      vram_we   <= vram_we_n;
      r0_done   <= r0_done_n;
      r1_done   <= r1_done_n;
      r0_q      <= r0_q_n;
      r1_q      <= r1_q_n;
      busy      <= busy_n;
    end
  end

  // Every output is registered, so each is computed here for the cycle it becomes visible in.
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    last_n      = last;
    op_we_n     = op_we;
    cnt_n       = cnt;
    vram_addr_n = vram_addr;
    vram_d_n    = vram_d;
    vram_we_n   = 1'b0;
    r0_done_n   = 1'b0;
    r1_done_n   = 1'b0;
    r0_q_n      = r0_q;
    r1_q_n      = r1_q;
    win         = 1'b0;

    case (state)
      S_IDLE: begin
        if (r0_req || r1_req) begin
          win         = (r0_req && r1_req) ? ~last : r1_req;
          owner_n     = win;
          last_n      = win;
          vram_addr_n = win ? r1_addr : r0_addr;
          vram_d_n    = win ? r1_d : r0_d;
          op_we_n     = win ? r1_we : r0_we;
          vram_we_n   = op_we_n;
          state_n     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_we) begin
          state_n   = S_DONE;
          r0_done_n = ~owner;
          r1_done_n = owner;
        end else begin
          state_n = S_WAIT;
          cnt_n   = CNT_W'(READ_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          if (owner) r1_q_n = vram_q;
          else       r0_q_n = vram_q;
          state_n   = S_DONE;
          r0_done_n = ~owner;
          r1_done_n = owner;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule
